// File: rtl/line_delay_taps.sv
// Multi-line pixel delay: NUM_LINES circular line RAMs with a runtime line length,
// giving NUM_LINES+1 vertically aligned taps with per-tap fill status.
module line_delay_taps #(
    parameter int DATA_W    = 12,
    parameter int LINE_LEN  = 640,
    parameter int NUM_LINES = 2,
    localparam int LEN_W    = $clog2(LINE_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          sof,
    input  logic [DATA_W-1:0]             datain,
    input  logic [LEN_W-1:0]              cfg_len,
    output logic                          out_valid,
    output logic [DATA_W*(NUM_LINES+1)-1:0] dataout,
    output logic [NUM_LINES:0]            tap_valid,
    output logic                          primed
);

    localparam int PTR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int CNT_W = $clog2(NUM_LINES * LINE_LEN + 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  addr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_cfg;
    logic [LEN_W-1:0]  len_use;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  c_use;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  sat;
    logic [NUM_LINES:0] tv;

    logic [DATA_W-1:0] mem [1:NUM_LINES][LINE_LEN];
    logic [DATA_W-1:0] rd  [NUM_LINES+1];

    always_comb begin
        len_cfg = (cfg_len == '0 || cfg_len > LEN_W'(LINE_LEN)) ? LEN_W'(LINE_LEN) : cfg_len;
    end

    // An accepted sof restarts the frame at address 0 with the freshly latched length.
    always_comb begin
        len_use = sof ? len_cfg : len_q;
        addr    = sof ? '0 : wr_ptr;
        c_use   = sof ? '0 : cnt;
        ptr_nxt = (LEN_W'(addr) == len_use - LEN_W'(1)) ? '0 : addr + PTR_W'(1);
        sat     = CNT_W'(NUM_LINES) * CNT_W'(len_use);
        cnt_nxt = (c_use >= sat) ? c_use : c_use + CNT_W'(1);
        tv      = '0;
        tv[0]   = 1'b1;
        for (int unsigned k = 1; k <= NUM_LINES; k++) begin
            tv[k] = (c_use >= CNT_W'(k) * CNT_W'(len_use));
        end
        rd[0] = datain;
        for (int unsigned k = 1; k <= NUM_LINES; k++) begin
            rd[k] = mem[k][addr];
        end
    end

    // Read-before-write cascade: line k stores what line k-1 held at this address.
    always_ff @(posedge clk) begin
        if (in_valid && !reset) begin
            for (int unsigned k = 1; k <= NUM_LINES; k++) begin
                mem[k][addr] <= rd[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            len_q     <= len_cfg;
            out_valid <= 1'b0;
            dataout   <= '0;
            tap_valid <= '0;
            primed    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                wr_ptr    <= ptr_nxt;
                cnt       <= cnt_nxt;
                if (sof) begin
                    len_q <= len_cfg;
                end
                tap_valid <= tv;
                primed    <= &tv;
                for (int unsigned k = 0; k <= NUM_LINES; k++) begin
                    dataout[k*DATA_W +: DATA_W] <= tv[k] ? rd[k] : '0;
                end
            end
        end
    end

endmodule
